// File: rtl/fb_pkg.sv
// Shared types for the framebuffer port arbiter: default widths and the RAM slot grant tag.
package fb_pkg;

    localparam int FB_AW = 16;
    localparam int FB_DW = 24;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_SCAN = 2'd1,
        G_WR   = 2'd2,
        G_RD   = 2'd3
    } fb_gnt_t;

    typedef logic [FB_DW-1:0] pixel_t;

endpackage

// File: rtl/fb_rr2.sv
// Two-requester round-robin picker; the pointer only moves when the caller reports a consumed grant.
module fb_rr2 (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // ptr_reg = 0 prefers requester 0, 1 prefers requester 1
    logic ptr_reg;
    logic ptr_next;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr_reg;
        if (ptr_reg) begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end else begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end
        if (advance && (gnt != 2'b00)) begin
            ptr_next = gnt[0];
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter: scanout fetches pre-empt everything, the pixel
// writer and reader share the remaining slots round-robin; responses are routed by a tag pipe.
import fb_pkg::*;

module fb_port_arbiter #(
    parameter int AW      = FB_AW,
    parameter int DW      = FB_DW,
    parameter int RAM_LAT = 1
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic [AW-1:0] scan_adr,
    input  logic          scan_en,
    output logic [DW-1:0] scan_d,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_adr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_adr,
    output logic          rd_rvalid,
    output logic [DW-1:0] rd_rdata,
    output logic [AW-1:0] ram_adr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int NSTG = RAM_LAT + 1;

    logic [AW-1:0] last_scan_adr_reg;
    logic [AW-1:0] ram_adr_reg;
    logic          ram_we_reg;
    logic [DW-1:0] ram_wdata_reg;
    logic [DW-1:0] scan_d_reg;
    logic [DW-1:0] rd_rdata_reg;
    logic          rd_rvalid_reg;

    logic          scan_req;
    logic [1:0]    host_gnt;
    logic          host_advance;
    fb_gnt_t       gnt;
    fb_gnt_t       tag_out;

    fb_rr2 u_rr (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .req      ({rd_valid, wr_valid}),
        .advance  (host_advance),
        .gnt      (host_gnt)
    );

    // A fetch is wanted whenever the visible address differs from the one last fetched;
    // since scanout always wins, a pending fetch is always served in the cycle it appears.
    always_comb begin
        scan_req = scan_en && (scan_adr != last_scan_adr_reg);
        gnt      = G_NONE;
        if (!reset) begin
            if (scan_req)         gnt = G_SCAN;
            else if (host_gnt[0]) gnt = G_WR;
            else if (host_gnt[1]) gnt = G_RD;
        end
    end

    assign host_advance = (gnt == G_WR) || (gnt == G_RD);
    assign wr_ready     = (gnt == G_WR);
    assign rd_ready     = (gnt == G_RD);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            last_scan_adr_reg <= '1;
            ram_adr_reg       <= '0;
            ram_we_reg        <= 1'b0;
            ram_wdata_reg     <= '0;
        end else begin
            ram_we_reg <= 1'b0;
            case (gnt)
                G_SCAN: begin
                    ram_adr_reg       <= scan_adr;
                    last_scan_adr_reg <= scan_adr;
                end
                G_WR: begin
                    ram_adr_reg   <= wr_adr;
                    ram_we_reg    <= 1'b1;
                    ram_wdata_reg <= wr_data;
                end
                G_RD: begin
                    ram_adr_reg <= rd_adr;
                end
                default: begin
                end
            endcase
        end
    end

    // Tag stage 0 is aligned with ram_adr; the last stage lines up with ram_rdata.
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_tag
        fb_gnt_t tag_reg;
        fb_gnt_t tag_in;
        if (gi == 0) begin : g_head
            assign tag_in = gnt;
        end else begin : g_body
            assign tag_in = g_tag[gi-1].tag_reg;
        end
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                tag_reg <= G_NONE;
            end else begin
                tag_reg <= tag_in;
            end
        end
    end

    assign tag_out = g_tag[NSTG-1].tag_reg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            scan_d_reg    <= '0;
            rd_rdata_reg  <= '0;
            rd_rvalid_reg <= 1'b0;
        end else begin
            rd_rvalid_reg <= (tag_out == G_RD);
            if (tag_out == G_SCAN) scan_d_reg   <= ram_rdata;
            if (tag_out == G_RD)   rd_rdata_reg <= ram_rdata;
        end
    end

    assign scan_d    = scan_d_reg;
    assign rd_rdata  = rd_rdata_reg;
    assign rd_rvalid = rd_rvalid_reg;
    assign ram_adr   = ram_adr_reg;
    assign ram_we    = ram_we_reg;
    assign ram_wdata = ram_wdata_reg;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: two instances (RAM_LAT=1 and 3) share stimulus; a transaction-level
// memory/arbitration model predicts readies, RAM writes, scan pixels and read returns.
module tb_fb_port_arbiter;
    import fb_pkg::*;

    localparam int NI = 2;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic        reset;
    logic        scan_en;
    logic [15:0] scan_adr;
    logic        wr_valid;
    logic [15:0] wr_adr;
    pixel_t      wr_data;
    logic        rd_valid;
    logic [15:0] rd_adr;

    pixel_t      scan_d    [NI];
    logic        wr_ready  [NI];
    logic        rd_ready  [NI];
    logic        rd_rvalid [NI];
    pixel_t      rd_rdata  [NI];
    logic [15:0] ram_adr   [NI];
    logic        ram_we    [NI];
    pixel_t      ram_wdata [NI];
    pixel_t      ram_rdata [NI];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Power-up RAM contents: address 0 holds 24'h112233.
    function automatic pixel_t dflt(input logic [15:0] a);
        return 24'h112233 + {a, a[7:0]};
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 1 : 3;

        fb_port_arbiter #(.AW(16), .DW(24), .RAM_LAT(L)) u_dut (
            .CLOCK_50  (CLOCK_50),
            .reset     (reset),
            .scan_adr  (scan_adr),
            .scan_en   (scan_en),
            .scan_d    (scan_d[gi]),
            .wr_valid  (wr_valid),
            .wr_ready  (wr_ready[gi]),
            .wr_adr    (wr_adr),
            .wr_data   (wr_data),
            .rd_valid  (rd_valid),
            .rd_ready  (rd_ready[gi]),
            .rd_adr    (rd_adr),
            .rd_rvalid (rd_rvalid[gi]),
            .rd_rdata  (rd_rdata[gi]),
            .ram_adr   (ram_adr[gi]),
            .ram_we    (ram_we[gi]),
            .ram_wdata (ram_wdata[gi]),
            .ram_rdata (ram_rdata[gi])
        );

        pixel_t mem [int];
        pixel_t pipe [3];

        always @(posedge CLOCK_50) begin : ram_model
            pixel_t rd0;
            rd0 = mem.exists(int'(ram_adr[gi])) ? mem[int'(ram_adr[gi])] : dflt(ram_adr[gi]);
            pipe[0] <= rd0;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            if (ram_we[gi]) mem[int'(ram_adr[gi])] = ram_wdata[gi];
        end

        assign ram_rdata[gi] = pipe[L-1];
    end

    typedef struct {
        pixel_t data;
        int     due;
    } exp_t;

    typedef struct {
        logic        sen;
        logic [15:0] sadr;
        logic        wv;
        logic        rv;
        logic        exp_wr;
        logic        exp_rd;
    } vec_t;

    pixel_t      ref_mem [int];
    logic [15:0] m_last;
    logic        m_last_wr;
    exp_t        scan_q [NI][$];
    exp_t        rd_q   [NI][$];
    pixel_t      cur_scan [NI];
    logic        exp_we;
    logic [15:0] exp_wa;
    pixel_t      exp_wd;
    logic        obs_wr [NI];
    logic        obs_rd [NI];
    int          dut_host_cnt [NI];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    function automatic pixel_t ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, req, cyc);
        end
    endtask

    // One clock cycle: drive inputs, predict grant, check readies, advance clock, check registered outputs.
    task automatic step(input logic rst, input logic sen, input logic [15:0] sadr,
                        input logic wv, input logic [15:0] wa, input pixel_t wd,
                        input logic rv, input logic [15:0] ra,
                        output logic gw, output logic gr);
        logic fetch;
        exp_t e;
        logic expv;
        reset = rst; scan_en = sen; scan_adr = sadr;
        wr_valid = wv; wr_adr = wa; wr_data = wd;
        rd_valid = rv; rd_adr = ra;
        #1;
        fetch = !rst && sen && (sadr != m_last);
        gw = 1'b0;
        gr = 1'b0;
        if (!rst && !fetch) begin
            if (wv && rv) begin
                gw = !m_last_wr;
                gr = m_last_wr;
            end else begin
                gw = wv;
                gr = rv;
            end
        end
        for (int i = 0; i < NI; i++) begin
            obs_wr[i] = wr_ready[i];
            obs_rd[i] = rd_ready[i];
            dut_host_cnt[i] += int'(wr_ready[i]) + int'(rd_ready[i]);
            chk($sformatf("wr_ready[%0d]", i), 32'(wr_ready[i]), 32'(gw));
            chk($sformatf("rd_ready[%0d]", i), 32'(rd_ready[i]), 32'(gr));
        end
        if (rst) begin
            m_last    = '1;
            m_last_wr = 1'b0;
            exp_we    = 1'b0;
            for (int i = 0; i < NI; i++) begin
                scan_q[i].delete();
                rd_q[i].delete();
                cur_scan[i] = '0;
            end
        end else begin
            if (fetch) begin
                m_last = sadr;
                for (int i = 0; i < NI; i++) begin
                    e.data = ref_rd(sadr);
                    e.due  = cyc + lat_of(i) + 2;
                    scan_q[i].push_back(e);
                end
            end
            if (gr) begin
                m_last_wr = 1'b0;
                for (int i = 0; i < NI; i++) begin
                    e.data = ref_rd(ra);
                    e.due  = cyc + lat_of(i) + 2;
                    rd_q[i].push_back(e);
                end
            end
            if (gw) begin
                m_last_wr = 1'b1;
                ref_mem[int'(wa)] = wd;
            end
            exp_we = gw;
            exp_wa = wa;
            exp_wd = wd;
        end
        @(posedge CLOCK_50);
        #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("ram_we[%0d]", i), 32'(ram_we[i]), 32'(exp_we));
            if (exp_we) begin
                chk($sformatf("ram_adr[%0d]", i), 32'(ram_adr[i]), 32'(exp_wa));
                chk($sformatf("ram_wdata[%0d]", i), 32'(ram_wdata[i]), 32'(exp_wd));
            end
            while (scan_q[i].size() > 0 && scan_q[i][0].due <= cyc) begin
                e = scan_q[i].pop_front();
                cur_scan[i] = e.data;
            end
            chk($sformatf("scan_d[%0d]", i), 32'(scan_d[i]), 32'(cur_scan[i]));
            expv = (rd_q[i].size() > 0) && (rd_q[i][0].due == cyc);
            chk($sformatf("rd_rvalid[%0d]", i), 32'(rd_rvalid[i]), 32'(expv));
            if (expv) begin
                e = rd_q[i].pop_front();
                chk($sformatf("rd_rdata[%0d]", i), 32'(rd_rdata[i]), 32'(e.data));
            end
        end
    endtask

    task automatic check_reset_vals();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_scan_d[%0d]", i),    32'(scan_d[i]),    32'h0);
            chk($sformatf("rst_rd_rdata[%0d]", i),  32'(rd_rdata[i]),  32'h0);
            chk($sformatf("rst_rd_rvalid[%0d]", i), 32'(rd_rvalid[i]), 32'h0);
            chk($sformatf("rst_ram_we[%0d]", i),    32'(ram_we[i]),    32'h0);
            chk($sformatf("rst_ram_adr[%0d]", i),   32'(ram_adr[i]),   32'h0);
            chk($sformatf("rst_ram_wdata[%0d]", i), 32'(ram_wdata[i]), 32'h0);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        vec_t        tbl [14];
        logic        gw, gr;
        logic        hwv, hrv;
        logic [15:0] hwa, hra, s;
        pixel_t      hwd;
        logic        sen;
        int          cnt_w, cnt_r, ncyc;

        tbl[0]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 16'h0008, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 16'h0008, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 16'h0008, 1'b1, 1'b1, 1'b1, 1'b0};

        for (int i = 0; i < NI; i++) begin
            dut_host_cnt[i] = 0;
            cur_scan[i] = '0;
        end
        m_last = '1; m_last_wr = 1'b0; exp_we = 1'b0;

        // Reset, then first scanout fetch from address 0
        step(1, 0, 16'h0, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);
        step(1, 0, 16'h0, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);
        check_reset_vals();
        step(0, 1, 16'h0, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);
        chk("scan_lat_early_1", 32'(scan_d[0]), 32'h0);
        step(0, 1, 16'h0, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);
        chk("scan_lat_early_2", 32'(scan_d[0]), 32'h0);
        step(0, 1, 16'h0, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);
        chk("scan_first_pixel_lat1", 32'(scan_d[0]), 32'h112233);
        step(0, 1, 16'h0, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);
        step(0, 1, 16'h0, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);
        chk("scan_first_pixel_lat3", 32'(scan_d[1]), 32'h112233);

        // Write then read back the same pixel
        step(0, 1, 16'h0, 1, 16'h0100, 24'hFF0000, 0, 16'h0, gw, gr);
        chk("wr_handshake", 32'(obs_wr[0]), 32'h1);
        chk("wr_ram_we", 32'(ram_we[0]), 32'h1);
        chk("wr_ram_adr", 32'(ram_adr[0]), 32'h0100);
        step(0, 1, 16'h0, 0, 16'h0, 24'h0, 1, 16'h0100, gw, gr);
        chk("rd_handshake", 32'(obs_rd[0]), 32'h1);
        step(0, 1, 16'h0, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);
        step(0, 1, 16'h0, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);
        chk("rd_back_rvalid", 32'(rd_rvalid[0]), 32'h1);
        chk("rd_back_rdata", 32'(rd_rdata[0]), 32'hFF0000);
        for (int k = 0; k < 4; k++) step(0, 1, 16'h0, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);

        // Table-driven arbitration vectors from a fresh reset
        step(1, 0, 16'h0, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);
        for (int v = 0; v < 14; v++) begin
            step(0, tbl[v].sen, tbl[v].sadr, tbl[v].wv, 16'h0020, 24'hABCDEF, tbl[v].rv, 16'h0020, gw, gr);
            chk($sformatf("tbl%0d_wr_ready", v), 32'(obs_wr[0]), 32'(tbl[v].exp_wr));
            chk($sformatf("tbl%0d_rd_ready", v), 32'(obs_rd[0]), 32'(tbl[v].exp_rd));
        end

        // Both hosts held for 8 cycles with no scan activity: strict alternation
        cnt_w = 0; cnt_r = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 16'h0008, 1, 16'h0030 + 16'(k), 24'h00FF00, 1, 16'h0030, gw, gr);
            cnt_w += int'(obs_wr[0]);
            cnt_r += int'(obs_rd[0]);
        end
        chk("alt_wr_count", 32'(cnt_w), 32'd4);
        chk("alt_rd_count", 32'(cnt_r), 32'd4);

        // Full-rate scanout over 0..279 then wrap to 0, both hosts saturated
        for (int i = 0; i < NI; i++) dut_host_cnt[i] = 0;
        ncyc = 0;
        hwa = 16'($urandom_range(0, 299)); hwd = pixel_t'($urandom); hra = 16'($urandom_range(0, 299));
        for (int a = 0; a <= 280; a++) begin
            s = (a == 280) ? 16'h0 : 16'(a);
            for (int k = 0; k < 4; k++) begin
                step(0, 1, s, 1, hwa, hwd, 1, hra, gw, gr);
                ncyc++;
                if (gw) begin hwa = 16'($urandom_range(0, 299)); hwd = pixel_t'($urandom); end
                if (gr) hra = 16'($urandom_range(0, 299));
            end
        end
        for (int i = 0; i < NI; i++)
            chk($sformatf("host_share[%0d]", i), 32'(dut_host_cnt[i] * 4 >= ncyc * 3), 32'h1);

        // Randomised traffic, including fast address changes and blanking
        hwv = 0; hrv = 0; s = 16'h0; sen = 1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 2) == 0) s = 16'($urandom_range(0, 15));
            sen = ($urandom_range(0, 5) != 0);
            if (!hwv) begin
                hwv = 1'($urandom_range(0, 1));
                hwa = 16'($urandom_range(0, 15));
                hwd = pixel_t'($urandom);
            end
            if (!hrv) begin
                hrv = 1'($urandom_range(0, 1));
                hra = 16'($urandom_range(0, 15));
            end
            step(0, sen, s, hwv, hwa, hwd, hrv, hra, gw, gr);
            if (gw) hwv = 0;
            if (gr) hrv = 0;
        end
        for (int k = 0; k < 6; k++) step(0, 0, s, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);

        // Reset while a read is in flight
        step(0, 0, s, 0, 16'h0, 24'h0, 1, 16'h0100, gw, gr);
        chk("inflight_rd_handshake", 32'(obs_rd[0]), 32'h1);
        step(1, 0, s, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);
        check_reset_vals();
        for (int k = 0; k < 6; k++) begin
            step(0, 0, s, 0, 16'h0, 24'h0, 0, 16'h0, gw, gr);
            chk("flushed_rvalid0", 32'(rd_rvalid[0]), 32'h0);
            chk("flushed_rvalid1", 32'(rd_rvalid[1]), 32'h0);
        end
        for (int i = 0; i < NI; i++)
            chk($sformatf("scoreboard_drained[%0d]", i), 32'(rd_q[i].size() + scan_q[i].size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
